// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - boot RAM image constants and dumper state encoding shared with the loader
package boot_pkg;

  localparam logic [15:0] IMAGE_LAST_ADDR = 16'h1FFF;
  localparam int          TIMER_W         = 24;

  typedef enum logic [3:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    TX_WAIT,
    ACK_WAIT,
    NEXT,
    CKSUM,
    DONE,
    ERR
  } dump_state_e;

  // Byte that brings the mod-256 sum of the whole stream to zero.
  function automatic logic [7:0] cksum_byte(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/uart_ram_dumper_if.sv
// rtl/uart_ram_dumper_if.sv - RAM read port, UART tx/rx and control/status bundle of the dumper
interface uart_ram_dumper_if;

  logic        start;
  logic [15:0] ram_addr;
  logic        ram_rd_en;
  logic [7:0]  ram_q;
  logic [7:0]  tx_data;
  logic        transmit;
  logic        tx_done;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, ram_q, tx_done, rx_data, rx_done,
    output ram_addr, ram_rd_en, tx_data, transmit, busy, done, error
  );

  modport slave (
    output start, ram_q, tx_done, rx_data, rx_done,
    input  ram_addr, ram_rd_en, tx_data, transmit, busy, done, error
  );

endinterface

// File: rtl/uart_pulse_latch.sv
// rtl/uart_pulse_latch.sv - sticky flag for a one-cycle UART pulse, cleared by transmit
module uart_pulse_latch (
  input  logic clk,
  input  logic boot_rst,
  input  logic pulse,
  input  logic clr,
  output logic seen
);

  logic flag_q;
  logic flag_d;

  // A pulse coincident with the clear belongs to the previous byte and is dropped.
  always_comb begin
    flag_d = clr ? 1'b0 : (flag_q | pulse);
  end

  always_ff @(posedge clk or posedge boot_rst) begin
    if (boot_rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  // Masked during the clear cycle so a stale flag never satisfies the new byte.
  assign seen = flag_q & ~clr;

endmodule

// File: rtl/uart_ram_dumper.sv
// rtl/uart_ram_dumper.sv - streams boot RAM 0..LAST_ADDR over UART TX and checks each host echo
// UART_RAM_DUMPER_CKSUM_EN appends a two's-complement checksum byte after the image.
module uart_ram_dumper
  import boot_pkg::*;
#(
  parameter logic [15:0]        LAST_ADDR  = IMAGE_LAST_ADDR,
  parameter int                 RD_LATENCY = 1,
  parameter logic [TIMER_W-1:0] TIMEOUT    = 24'd10_000_000
) (
  input logic               clk,
  input logic               boot_rst,
  uart_ram_dumper_if.master bus
);

  localparam logic [1:0]         LAT_LOAD  = 2'(RD_LATENCY - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  dump_state_e        state_q;
  logic [15:0]        ram_addr_q;
  logic               ram_rd_en_q;
  logic [7:0]         tx_data_q;
  logic               transmit_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic [TIMER_W-1:0] timer_q;
  logic [1:0]         lat_q;
  logic [7:0]         rx_byte_q;
`ifdef UART_RAM_DUMPER_CKSUM_EN
  logic [7:0]         sum_q;
  logic               cks_phase_q;
`endif

  logic               rx_seen;
  logic               tx_seen;
  logic [TIMER_W-1:0] timer_d;
  logic               timed_out;

  uart_pulse_latch u_rx_latch (
    .clk      (clk),
    .boot_rst (boot_rst),
    .pulse    (bus.rx_done),
    .clr      (transmit_q),
    .seen     (rx_seen)
  );

  uart_pulse_latch u_tx_latch (
    .clk      (clk),
    .boot_rst (boot_rst),
    .pulse    (bus.tx_done),
    .clr      (transmit_q),
    .seen     (tx_seen)
  );

  always_comb begin
    timer_d   = (timer_q == '1) ? timer_q : timer_q + TIMER_ONE;
    timed_out = (timer_q >= TIMEOUT - TIMER_ONE);
  end

  // Outputs are loaded on the transition into a state so they are valid while in it.
  always_ff @(posedge clk or posedge boot_rst) begin
    if (boot_rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_rd_en_q <= 1'b0;
      tx_data_q   <= '0;
      transmit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      timer_q     <= '0;
      lat_q       <= '0;
      rx_byte_q   <= '0;
`ifdef UART_RAM_DUMPER_CKSUM_EN
      sum_q       <= '0;
      cks_phase_q <= 1'b0;
`endif
    end else begin
      ram_rd_en_q <= 1'b0;
      transmit_q  <= 1'b0;
      timer_q     <= '0;
      if (bus.rx_done) begin
        rx_byte_q <= bus.rx_data;
      end
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RD_ISSUE;
            ram_addr_q  <= '0;
            ram_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef UART_RAM_DUMPER_CKSUM_EN
            sum_q       <= '0;
            cks_phase_q <= 1'b0;
`endif
          end
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
          lat_q   <= LAT_LOAD;
        end
        RD_WAIT: begin
          if (lat_q == 2'd0) begin
            state_q    <= TX_WAIT;
            tx_data_q  <= bus.ram_q;
            transmit_q <= 1'b1;
`ifdef UART_RAM_DUMPER_CKSUM_EN
            sum_q      <= sum_q + bus.ram_q;
`endif
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        TX_WAIT: begin
          if (tx_seen) begin
            state_q <= ACK_WAIT;
          end else if (timed_out) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            timer_q <= timer_d;
          end
        end
        ACK_WAIT: begin
          if (rx_seen && rx_byte_q == tx_data_q) begin
`ifdef UART_RAM_DUMPER_CKSUM_EN
            if (cks_phase_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= NEXT;
            end
`else
            state_q <= NEXT;
`endif
          end else if (rx_seen || timed_out) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            timer_q <= timer_d;
          end
        end
        NEXT: begin
          if (ram_addr_q == LAST_ADDR) begin
`ifdef UART_RAM_DUMPER_CKSUM_EN
            state_q <= CKSUM;
`else
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q     <= RD_ISSUE;
            ram_addr_q  <= ram_addr_q + 16'd1;
            ram_rd_en_q <= 1'b1;
          end
        end
`ifdef UART_RAM_DUMPER_CKSUM_EN
        CKSUM: begin
          state_q     <= TX_WAIT;
          tx_data_q   <= cksum_byte(sum_q);
          transmit_q  <= 1'b1;
          cks_phase_q <= 1'b1;
        end
`endif
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_rd_en = ram_rd_en_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.transmit  = transmit_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule
